// File: rtl/vga_axil_master_fsm_if.sv
// AXI-Lite master/slave bundle (AW, W, B, AR, R channels) used between
// vga_axil_master_fsm and the AXI-Lite slave it drives.
interface vga_axil_master_fsm_if #(
  parameter int unsigned AXIL_ADDR_WIDTH = 32,
  parameter int unsigned AXIL_DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = AXIL_DATA_WIDTH / 8;

  logic [AXIL_ADDR_WIDTH-1:0] awaddr;
  logic                       awvalid;
  logic                       awready;
  logic [AXIL_DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]          wstrb;
  logic                       wvalid;
  logic                       wready;
  logic [1:0]                 bresp;
  logic                       bvalid;
  logic                       bready;
  logic [AXIL_ADDR_WIDTH-1:0] araddr;
  logic                       arvalid;
  logic                       arready;
  logic [AXIL_DATA_WIDTH-1:0] rdata;
  logic [1:0]                 rresp;
  logic                       rvalid;
  logic                       rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/vga_axil_master_fsm.sv
// Native single-request port to AXI-Lite master bridge. One transaction in
// flight at a time; every control output is a flop loaded from next state.
// Optional: define VGA_AXIL_MASTER_ERR_CNT_EN to add err_cnt_o, a saturating
// count of non-OKAY responses.
module vga_axil_master_fsm #(
  parameter int unsigned AXIL_ADDR_WIDTH = 32,
  parameter int unsigned AXIL_DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_write_i,
  input  logic [AXIL_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [AXIL_DATA_WIDTH-1:0] req_wdata_i,
  output logic                       rsp_valid_o,
  output logic [AXIL_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]                 rsp_resp_o,
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
  output logic [7:0]                 err_cnt_o,
`endif
  vga_axil_master_fsm_if.master      axil_io
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  state_e                     state_q, state_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q, w_done_d;
  logic [AXIL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXIL_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                 resp_q, resp_d;
  logic                       req_ready_q, req_ready_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic                       bready_q, bready_d;
  logic                       arvalid_q, arvalid_d;
  logic                       rready_q, rready_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       aw_hs, w_hs, b_hs, ar_hs, r_hs;
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
  logic [7:0]                 err_cnt_q, err_cnt_d;
`endif

  // Next-state, captured payloads and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    aw_hs       = awvalid_q & axil_io.awready;
    w_hs        = wvalid_q  & axil_io.wready;
    b_hs        = bready_q  & axil_io.bvalid;
    ar_hs       = arvalid_q & axil_io.arready;
    r_hs        = rready_q  & axil_io.rvalid;
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
    err_cnt_d   = err_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          addr_d    = req_addr_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_write_i) begin
            wdata_d = req_wdata_i;
            state_d = WR_REQ;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          resp_d  = axil_io.bresp;
          state_d = RSP;
        end
      end
      RD_REQ: begin
        if (ar_hs) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (r_hs) begin
          rdata_d = axil_io.rdata;
          resp_d  = axil_io.rresp;
          state_d = RSP;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
    // Count once, on the edge that enters RSP with a non-OKAY response
    if ((state_d == RSP) && (state_q != RSP) && (resp_d != RESP_OKAY) &&
        (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
`endif

    req_ready_d = (state_d == IDLE);
    awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == WR_REQ) && !w_done_d;
    bready_d    = (state_d == WR_RESP);
    arvalid_d   = (state_d == RD_REQ);
    rready_d    = (state_d == RD_RESP);
    rsp_valid_d = (state_d == RSP);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      req_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
      err_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign req_ready_o     = req_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rdata_q;
  assign rsp_resp_o      = resp_q;
  assign axil_io.awaddr  = addr_q;
  assign axil_io.awvalid = awvalid_q;
  assign axil_io.wdata   = wdata_q;
  assign axil_io.wstrb   = '1;
  assign axil_io.wvalid  = wvalid_q;
  assign axil_io.bready  = bready_q;
  assign axil_io.araddr  = addr_q;
  assign axil_io.arvalid = arvalid_q;
  assign axil_io.rready  = rready_q;
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
  assign err_cnt_o       = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_axil_master_fsm.sv
// Self-checking bench for vga_axil_master_fsm: directed scenarios plus
// randomized transactions against a transaction-level reference model.
// Define VGA_AXIL_MASTER_ERR_CNT_EN to exercise the error counter.
module tb_vga_axil_master_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: last read data, last response, error count
  logic [31:0] m_rdata;
  logic [1:0]  m_resp;
  int          m_err;

  vga_axil_master_fsm_if #(.AXIL_ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32)) bus ();

  vga_axil_master_fsm #(.AXIL_ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_resp_o  (rsp_resp),
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
    .err_cnt_o   (err_cnt),
`endif
    .axil_io     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request and act as the AXI-Lite slave until the response pulse.
  // *_d are wait cycles before the slave readies/responds.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int aw_d, input int w_d, input int b_d,
                         input int ar_d, input int r_d,
                         input logic [31:0] rd, input logic [1:0] resp, input bit hold);
    int aw_hi, w_hi, ar_hi, b_wait, r_wait;
    int aw_n, w_n, b_n, ar_n, r_n;
    int exp_lat;
    bit done;
    aw_hi = 0; w_hi = 0; ar_hi = 0; b_wait = 0; r_wait = 0;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    done = 1'b0;
    exp_lat = wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;

    @(negedge clk);
    chk("rsp_pulse_len", 32'(rsp_valid), 32'd0);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    chk("rdata_hold", rsp_rdata, m_rdata);
    chk("resp_hold", 32'(rsp_resp), 32'(m_resp));
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;

    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (rsp_valid) begin
        done = 1'b1;
        m_resp = resp;
        if (!wr) m_rdata = rd;
        if (resp != 2'b00 && m_err < 255) m_err++;
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("rsp_resp", 32'(rsp_resp), 32'(m_resp));
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("bus_idle_at_rsp", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 32'd0);
        chk("aw_hs_count", 32'(aw_n), wr ? 32'd1 : 32'd0);
        chk("w_hs_count", 32'(w_n), wr ? 32'd1 : 32'd0);
        chk("b_hs_count", 32'(b_n), wr ? 32'd1 : 32'd0);
        chk("ar_hs_count", 32'(ar_n), wr ? 32'd0 : 32'd1);
        chk("r_hs_count", 32'(r_n), wr ? 32'd0 : 32'd1);
        chk("awvalid_cycles", 32'(aw_hi), wr ? 32'(aw_d + 1) : 32'd0);
        chk("wvalid_cycles", 32'(w_hi), wr ? 32'(w_d + 1) : 32'd0);
        chk("arvalid_cycles", 32'(ar_hi), wr ? 32'd0 : 32'(ar_d + 1));
`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.rvalid = 1'b0;
      end else begin
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (bus.awvalid) begin
          chk("awaddr", bus.awaddr, addr);
          aw_hi++;
          bus.awready = (aw_hi > aw_d);
          if (bus.awready) aw_n++;
        end else bus.awready = 1'b0;
        if (bus.wvalid) begin
          chk("wdata", bus.wdata, data);
          chk("wstrb", 32'(bus.wstrb), 32'hF);
          w_hi++;
          bus.wready = (w_hi > w_d);
          if (bus.wready) w_n++;
        end else bus.wready = 1'b0;
        if (bus.arvalid) begin
          chk("araddr", bus.araddr, addr);
          ar_hi++;
          bus.arready = (ar_hi > ar_d);
          if (bus.arready) ar_n++;
        end else bus.arready = 1'b0;
        // Responses honour ready; stray valids outside the response states are noise
        if (bus.bready) begin
          b_wait++;
          bus.bvalid = (b_wait > b_d);
          bus.bresp  = bus.bvalid ? resp : 2'($urandom);
          if (bus.bvalid) b_n++;
        end else begin
          bus.bvalid = ($urandom_range(0, 3) == 0);
          bus.bresp  = 2'($urandom);
        end
        if (bus.rready) begin
          r_wait++;
          bus.rvalid = (r_wait > r_d);
          bus.rdata  = bus.rvalid ? rd : $urandom;
          bus.rresp  = bus.rvalid ? resp : 2'($urandom);
          if (bus.rvalid) r_n++;
        end else begin
          bus.rvalid = ($urandom_range(0, 3) == 0);
          bus.rdata  = $urandom;
          bus.rresp  = 2'($urandom);
        end
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    m_rdata = '0; m_resp = 2'b00; m_err = 0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_resp", 32'(rsp_resp), 32'd0);
    chk("rst_awaddr", bus.awaddr, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    rst = 1'b0;

    // Zero-wait write, delayed AW, delayed-response read
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0, 2'b00, 1'b0);
    run_txn(1'b1, 32'h14, 32'hCAFEF00D, 3, 0, 0, 0, 0, 32'h0, 2'b00, 1'b0);
    run_txn(1'b1, 32'h18, 32'h0BADC0DE, 0, 2, 1, 0, 0, 32'h0, 2'b01, 1'b0);
    run_txn(1'b0, 32'h20, 32'h0, 0, 0, 0, 0, 2, 32'h12345678, 2'b00, 1'b0);

    // req_valid held high across back-to-back transactions
    run_txn(1'b1, 32'h40, 32'h11112222, 1, 2, 1, 0, 0, 32'h0, 2'b00, 1'b1);
    run_txn(1'b0, 32'h44, 32'h0, 0, 0, 0, 1, 0, 32'hA5A55A5A, 2'b00, 1'b1);
    run_txn(1'b1, 32'h48, 32'h33334444, 0, 0, 0, 0, 0, 32'h0, 2'b00, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              $urandom, 2'($urandom), (i != 39) && ($urandom_range(0, 1) == 1));
    end

    // Reset while waiting for the write response
    @(negedge clk);
    chk("pre_rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h55AA55AA;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      bus.awready = bus.awvalid;
      bus.wready  = bus.wvalid;
      bus.bvalid  = 1'b0;
      if (bus.bready) break;
    end
    chk("reached_wr_resp", 32'(bus.bready), 32'd1);
    rst = 1'b1;
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b1; bus.bresp = 2'b10;
    @(negedge clk);
    chk("rst_abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_abort_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 32'd0);
    chk("rst_abort_req_ready", 32'(req_ready), 32'd0);
    chk("rst_abort_resp", 32'(rsp_resp), 32'd0);
    chk("rst_abort_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    bus.bvalid = 1'b0;
    m_rdata = '0; m_resp = 2'b00; m_err = 0;
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    run_txn(1'b0, 32'h84, 32'h0, 2, 0, 0, 1, 1, 32'hFEEDFACE, 2'b11, 1'b0);

`ifdef VGA_AXIL_MASTER_ERR_CNT_EN
    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      run_txn(1'b0, 32'(i * 4), 32'h0, 0, 0, 0, 0, 0, $urandom, 2'b10, 1'b0);
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    chk("err_resp_slverr", 32'(rsp_resp), 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
